// File: rtl/adc_sample_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : adc_sample_sequencer
//  Purpose  : Fixed-rate ADC conversion sequencer feeding the serial reader.
//             Optional DSP frame alignment input when SAMPLE_SYNC_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module adc_sample_sequencer #(
    parameter int ADC_CHIP_NO  = 4,
    parameter int SAMPLE_DIV   = 1500,
    parameter int CONVST_LOW   = 4,
    parameter int BUSY_BLANK   = 2,
    parameter int CONV_TIMEOUT = 200,
    parameter int XFER_CLKS    = 116
) (
    input  logic                   clkin,
    input  logic                   rst,
    input  logic                   run,
    input  logic                   clr_err,
`ifdef SAMPLE_SYNC_EN
    input  logic                   sync_in,
`endif
    input  logic [ADC_CHIP_NO-1:0] busy,
    output logic                   convst_bar,
    output logic                   enable,
    output logic                   active,
    output logic [15:0]            frame_cnt,
    output logic                   overrun,
    output logic                   conv_timeout
);

    localparam logic [15:0] c_DIV_LAST     = 16'(SAMPLE_DIV - 1);
    localparam logic [15:0] c_CONVST_LAST  = 16'(CONVST_LOW - 1);
    localparam logic [15:0] c_BLANK_LAST   = 16'(BUSY_BLANK - 1);
    localparam logic [15:0] c_TIMEOUT_LAST = 16'(CONV_TIMEOUT - 1);
    localparam logic [15:0] c_XFER_LAST    = 16'(XFER_CLKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CONVST    = 3'd1,
        ST_BLANK     = 3'd2,
        ST_WAIT_CONV = 3'd3,
        ST_TRIG      = 3'd4,
        ST_XFER      = 3'd5
    } state_t;

    state_t                 r_state;
    logic [15:0]            r_div_cnt;
    logic [15:0]            r_phase_cnt;
    logic [ADC_CHIP_NO-1:0] r_busy_s1;
    logic [ADC_CHIP_NO-1:0] r_busy_s2;
    logic                   r_convst_bar;
    logic                   r_enable;
    logic                   r_active;
    logic [15:0]            r_frame_cnt;
    logic                   r_overrun;
    logic                   r_conv_timeout;
    logic                   w_tick;
    logic                   w_busy_any;

    always_ff @(posedge clkin) begin
        if (rst) begin
            r_busy_s1 <= '0;
            r_busy_s2 <= '0;
        end else begin
            r_busy_s1 <= busy;
            r_busy_s2 <= r_busy_s1;
        end
    end

    assign w_busy_any = |r_busy_s2;

`ifdef SAMPLE_SYNC_EN
    logic r_sync_s1;
    logic r_sync_s2;
    logic r_sync_s3;
    logic w_sync_rise;

    always_ff @(posedge clkin) begin
        if (rst) begin
            r_sync_s1 <= 1'b0;
            r_sync_s2 <= 1'b0;
            r_sync_s3 <= 1'b0;
        end else begin
            r_sync_s1 <= sync_in;
            r_sync_s2 <= r_sync_s1;
            r_sync_s3 <= r_sync_s2;
        end
    end

    assign w_sync_rise = r_sync_s2 & ~r_sync_s3;
`endif

    assign w_tick = run && (r_div_cnt == c_DIV_LAST);

    // The wrap has priority over a sync edge so a coinciding tick is still emitted.
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (!run) begin
            r_div_cnt <= '0;
        end else if (r_div_cnt == c_DIV_LAST) begin
            r_div_cnt <= '0;
`ifdef SAMPLE_SYNC_EN
        end else if (w_sync_rise) begin
            r_div_cnt <= '0;
`endif
        end else begin
            r_div_cnt <= r_div_cnt + 16'd1;
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_phase_cnt    <= '0;
            r_convst_bar   <= 1'b1;
            r_enable       <= 1'b0;
            r_active       <= 1'b0;
            r_frame_cnt    <= '0;
            r_overrun      <= 1'b0;
            r_conv_timeout <= 1'b0;
        end else begin
            r_enable <= 1'b0;

            // A new error event in the same cycle as clr_err leaves the flag set.
            if (w_tick && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end
            if (clr_err) begin
                r_conv_timeout <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_state      <= ST_CONVST;
                        r_convst_bar <= 1'b0;
                        r_phase_cnt  <= '0;
                        r_active     <= 1'b1;
                    end
                end
                ST_CONVST: begin
                    if (r_phase_cnt == c_CONVST_LAST) begin
                        r_state      <= ST_BLANK;
                        r_convst_bar <= 1'b1;
                        r_phase_cnt  <= '0;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + 16'd1;
                    end
                end
                ST_BLANK: begin
                    if (r_phase_cnt == c_BLANK_LAST) begin
                        r_state     <= ST_WAIT_CONV;
                        r_phase_cnt <= '0;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + 16'd1;
                    end
                end
                ST_WAIT_CONV: begin
                    if (!w_busy_any) begin
                        r_state     <= ST_TRIG;
                        r_enable    <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end else if (r_phase_cnt == c_TIMEOUT_LAST) begin
                        r_state        <= ST_IDLE;
                        r_conv_timeout <= 1'b1;
                        r_active       <= 1'b0;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + 16'd1;
                    end
                end
                ST_TRIG: begin
                    r_state     <= ST_XFER;
                    r_phase_cnt <= '0;
                end
                ST_XFER: begin
                    if (r_phase_cnt == c_XFER_LAST) begin
                        r_state  <= ST_IDLE;
                        r_active <= 1'b0;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_convst_bar <= 1'b1;
                    r_active     <= 1'b0;
                end
            endcase
        end
    end

    assign convst_bar   = r_convst_bar;
    assign enable       = r_enable;
    assign active       = r_active;
    assign frame_cnt    = r_frame_cnt;
    assign overrun      = r_overrun;
    assign conv_timeout = r_conv_timeout;

endmodule
`default_nettype wire
